// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit with HI/LO:
// operation encodings, FSM state encoding and the divide-by-zero quotient.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Quotient reported on divide by zero: all ones, sliced to DATA_W at the use site.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: yields |val| when neg marks a negative
// input, and applies the result sign when neg marks a negative result.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  // Negate under the sign flag, pass through otherwise.
  always_comb begin
    res = neg ? -val : val;
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Sequence: IDLE -> PREP (abs/signs) -> ITER (DATA_W steps) -> FIX (sign
// correction, HI/LO commit). MTHI/MTLO write HI/LO directly while idle.
// Optional build macro MULDIV_ZERO_SHORTCUT_EN: zero multiply operands or a
// zero divisor skip ITER (PREP -> FIX), with unchanged results.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src0_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic              mthi_i,
  input  logic              mtlo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  md_state_e         state_q, state_d;
  md_op_e            op_q;
  logic [DATA_W-1:0] src0_q, src1_q;
  logic [DATA_W-1:0] opnd_q;       // multiplicand or divisor magnitude
  logic [DATA_W-1:0] work_hi_q;    // product high half / partial remainder
  logic [DATA_W-1:0] work_lo_q;    // multiplier shifting out / quotient shifting in
  logic              neg_lo_q;     // product or quotient is negative
  logic              neg_hi_q;     // remainder is negative
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              busy_q, done_q;

  logic              is_mul, is_signed, accept, mt_ok, zero_skip, div0;
  logic [DATA_W-1:0] abs0, abs1;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix, res_hi, res_lo;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  muldiv_sign_fix #(.WIDTH(DATA_W)) u_abs0 (
    .val (src0_q),
    .neg (is_signed & src0_q[DATA_W-1]),
    .res (abs0)
  );

  muldiv_sign_fix #(.WIDTH(DATA_W)) u_abs1 (
    .val (src1_q),
    .neg (is_signed & src1_q[DATA_W-1]),
    .res (abs1)
  );

  muldiv_sign_fix #(.WIDTH(2 * DATA_W)) u_fix_prod (
    .val ({work_hi_q, work_lo_q}),
    .neg (neg_lo_q),
    .res (prod_fix)
  );

  muldiv_sign_fix #(.WIDTH(DATA_W)) u_fix_quo (
    .val (work_lo_q),
    .neg (neg_lo_q),
    .res (quo_fix)
  );

  muldiv_sign_fix #(.WIDTH(DATA_W)) u_fix_rem (
    .val (work_hi_q),
    .neg (neg_hi_q),
    .res (rem_fix)
  );

  // Operation decode, handshake qualifiers and the single-step datapath.
  always_comb begin
    is_mul    = (op_q == MD_MULT) || (op_q == MD_MULTU);
    is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    accept    = (state_q == ST_IDLE) && start_i && !flush_i;
    mt_ok     = (state_q == ST_IDLE) && !start_i && !flush_i;
    div0      = !is_mul && (src1_q == '0);
`ifdef MULDIV_ZERO_SHORTCUT_EN
    zero_skip = is_mul ? ((src0_q == '0) || (src1_q == '0)) : (src1_q == '0);
`else
    zero_skip = 1'b0;
`endif

    // Shift-add multiply: add multiplicand when the multiplier LSB is set,
    // then shift the {hi,lo} pair right by one.
    mul_sum   = {1'b0, work_hi_q} + {1'b0, opnd_q};
    // Restoring divide: shift the next dividend bit into the remainder and
    // trial-subtract; the remainder stays below the divisor so the borrow bit
    // is a reliable sign.
    div_shift = {work_hi_q, work_lo_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};

    if (is_mul) begin
      if (work_lo_q[0]) begin
        step_hi = mul_sum[DATA_W:1];
        step_lo = {mul_sum[0], work_lo_q[DATA_W-1:1]};
      end else begin
        step_hi = {1'b0, work_hi_q[DATA_W-1:1]};
        step_lo = {work_hi_q[0], work_lo_q[DATA_W-1:1]};
      end
    end else begin
      step_hi = div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
      step_lo = {work_lo_q[DATA_W-2:0], ~div_diff[DATA_W]};
    end

    // Divide by zero bypasses the iterated values: the dividend is returned
    // raw in HI, never sign-corrected.
    if (is_mul) begin
      res_hi = prod_fix[2*DATA_W-1:DATA_W];
      res_lo = prod_fix[DATA_W-1:0];
    end else if (div0) begin
      res_hi = src0_q;
      res_lo = DIV0_QUOTIENT[DATA_W-1:0];
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a flush returns any active state to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PREP;
      ST_PREP: state_d = zero_skip ? ST_FIX : ST_ITER;
      ST_ITER: if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Operand capture, iteration registers, HI/LO and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= MD_MULT;
      src0_q    <= '0;
      src1_q    <= '0;
      opnd_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= md_op_e'(op_i);
            src0_q <= src0_i;
            src1_q <= src1_i;
          end else if (mt_ok) begin
            if (mthi_i) hi_q <= wdata_i;
            if (mtlo_i) lo_q <= wdata_i;
          end
        end
        ST_PREP: begin
          cnt_q     <= '0;
          work_hi_q <= '0;
          neg_lo_q  <= is_signed & (src0_q[DATA_W-1] ^ src1_q[DATA_W-1]);
          neg_hi_q  <= is_signed & src0_q[DATA_W-1];
          if (is_mul) begin
            opnd_q    <= abs0;
            work_lo_q <= abs1;
          end else begin
            opnd_q    <= abs1;
            work_lo_q <= abs0;
          end
          // A skipped multiply must still present a zero product to FIX.
          if (is_mul && zero_skip) work_lo_q <= '0;
        end
        ST_ITER: begin
          cnt_q     <= cnt_q + CNT_W'(1);
          work_hi_q <= step_hi;
          work_lo_q <= step_lo;
        end
        ST_FIX: begin
          if (!flush_i) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed-vector bench for muldiv_hilo_unit: arithmetic results, busy length,
// done pulse, MTHI/MTLO, start-while-busy, flush and asynchronous reset.
module tb_muldiv_hilo_unit;

  localparam int unsigned W = 32;
`ifdef MULDIV_ZERO_SHORTCUT_EN
  localparam int unsigned ZB = 2;
`else
  localparam int unsigned ZB = 34;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] src0_i, src1_i, wdata_i;
  logic         mthi_i, mtlo_i, flush_i;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  muldiv_hilo_unit #(.DATA_W(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .src0_i  (src0_i),
    .src1_i  (src1_i),
    .mthi_i  (mthi_i),
    .mtlo_i  (mtlo_i),
    .wdata_i (wdata_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an operation for one cycle; returns at the negedge of busy cycle 1.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; src0_i = a; src1_i = b;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Count remaining busy cycles (n0 already seen), then check the done cycle.
  task automatic wait_done(input string tag, input int unsigned n0, input int unsigned exp_busy,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int unsigned n = n0;
    while (busy_o === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    chk({tag, ".busy"}, n, exp_busy);
    chk({tag, ".done"}, {31'd0, done_o}, 32'd1);
    chk({tag, ".hi"}, hi_o, ehi);
    chk({tag, ".lo"}, lo_o, elo);
    @(negedge clk_i);
    chk({tag, ".done_drop"}, {31'd0, done_o}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned exp_busy,
                        input logic [31:0] ehi, input logic [31:0] elo);
    launch(op, a, b);
    wait_done(tag, 0, exp_busy, ehi, elo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; src0_i = '0; src1_i = '0;
    mthi_i = 1'b0; mtlo_i = 1'b0; wdata_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst.busy", {31'd0, busy_o}, 32'd0);
    chk("rst.done", {31'd0, done_o}, 32'd0);
    chk("rst.hi", hi_o, 32'h0);
    chk("rst.lo", lo_o, 32'h0);
    rst_i = 1'b0;

    run_op("mult_neg2x3",  2'b00, 32'hFFFFFFFE, 32'd3,        34, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_m7_2",     2'b10, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_m1",   2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000);
    run_op("div_7_m2",     2'b10, 32'd7,        32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_100_7",   2'b11, 32'd100,      32'd7,        34, 32'h00000002, 32'h0000000E);
    run_op("divu_7_0",     2'b11, 32'd7,        32'd0,        ZB, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_m7_0",     2'b10, 32'hFFFFFFF9, 32'd0,        ZB, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("mult_0x5",     2'b00, 32'd0,        32'd5,        ZB, 32'h00000000, 32'h00000000);

    // MTHI / MTLO while idle
    @(negedge clk_i); mthi_i = 1'b1; wdata_i = 32'h11;
    @(negedge clk_i); mthi_i = 1'b0;
    chk("mthi.hi", hi_o, 32'h11);
    chk("mthi.lo", lo_o, 32'h0);
    mtlo_i = 1'b1; wdata_i = 32'h22;
    @(negedge clk_i); mtlo_i = 1'b0;
    chk("mtlo.lo", lo_o, 32'h22);
    chk("mtlo.hi", hi_o, 32'h11);
    mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'h33;
    @(negedge clk_i); mthi_i = 1'b0; mtlo_i = 1'b0;
    chk("mtboth.hi", hi_o, 32'h33);
    chk("mtboth.lo", lo_o, 32'h33);

    // Flush in IDLE blocks same-cycle start and MTHI
    start_i = 1'b1; flush_i = 1'b1; mthi_i = 1'b1; wdata_i = 32'h44;
    op_i = 2'b01; src0_i = 32'd2; src1_i = 32'd3;
    @(negedge clk_i); start_i = 1'b0; flush_i = 1'b0; mthi_i = 1'b0;
    chk("idleflush.busy", {31'd0, busy_o}, 32'd0);
    chk("idleflush.hi", hi_o, 32'h33);

    // Start together with MTLO: start wins, write dropped
    start_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'h55;
    op_i = 2'b01; src0_i = 32'd2; src1_i = 32'd3;
    @(negedge clk_i); start_i = 1'b0; mtlo_i = 1'b0;
    chk("startmt.busy", {31'd0, busy_o}, 32'd1);
    chk("startmt.lo", lo_o, 32'h33);
    wait_done("startmt", 0, 34, 32'h0, 32'h6);

    // Start and MTLO while busy are both ignored
    launch(2'b01, 32'd3, 32'd5);
    repeat (5) @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b10; src0_i = 32'd100; src1_i = 32'd7;
    mtlo_i = 1'b1; wdata_i = 32'hAA;
    @(negedge clk_i); start_i = 1'b0; mtlo_i = 1'b0;
    chk("busyign.lo_mid", lo_o, 32'h6);
    wait_done("busyign", 6, 34, 32'h0, 32'hF);

    // Flush at busy cycle 10
    launch(2'b00, 32'd5, 32'd5);
    repeat (9) @(negedge clk_i);
    chk("flush.busy_before", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i); flush_i = 1'b0;
    chk("flush.busy", {31'd0, busy_o}, 32'd0);
    chk("flush.done", {31'd0, done_o}, 32'd0);
    chk("flush.hi", hi_o, 32'h0);
    chk("flush.lo", lo_o, 32'hF);
    repeat (40) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || busy_o !== 1'b0) break;
    end
    chk("flush.no_done", {30'd0, busy_o, done_o}, 32'd0);

    // Asynchronous reset mid-DIV
    run_op("pre_rst", 2'b00, 32'hFFFFFFFE, 32'd3, 34, 32'hFFFFFFFF, 32'hFFFFFFFA);
    launch(2'b10, 32'd100, 32'd7);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("arst.busy", {31'd0, busy_o}, 32'd0);
    chk("arst.done", {31'd0, done_o}, 32'd0);
    chk("arst.hi", hi_o, 32'h0);
    chk("arst.lo", lo_o, 32'h0);
    @(negedge clk_i); rst_i = 1'b0;

    run_op("post_rst", 2'b11, 32'd100, 32'd7, 34, 32'h00000002, 32'h0000000E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
